// File: rtl/apb_cordic_slave_pkg.sv
// Shared definitions for the APB CORDIC completer: register map offsets,
// CTRL/STATUS bit positions, engine state encoding and the arctangent table.
package apb_cordic_slave_pkg;

    // Register offsets, decoded from PADDR[4:2]
    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_X_IN   = 3'd2;
    localparam logic [2:0] ADDR_Y_IN   = 3'd3;
    localparam logic [2:0] ADDR_Z_IN   = 3'd4;
    localparam logic [2:0] ADDR_X_OUT  = 3'd5;
    localparam logic [2:0] ADDR_Y_OUT  = 3'd6;
    localparam logic [2:0] ADDR_Z_OUT  = 3'd7;

    // CTRL bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_MODE  = 1;
    localparam int CTRL_IE    = 2;

    // STATUS bit positions
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;

    // Engine states
    typedef enum logic {
        ENG_IDLE = 1'b0,
        ENG_RUN  = 1'b1
    } eng_state_e;

    localparam int ATAN_W = 16;

    // atan(2^-i) in Q2.13 (0x2000 = 1.0 rad), rounded to nearest
    function automatic logic [ATAN_W-1:0] atan_rom(input logic [3:0] idx);
        logic [ATAN_W-1:0] v;
        case (idx)
            4'd0:    v = 16'h1922;
            4'd1:    v = 16'h0ED6;
            4'd2:    v = 16'h07D7;
            4'd3:    v = 16'h03FB;
            4'd4:    v = 16'h01FF;
            4'd5:    v = 16'h0100;
            4'd6:    v = 16'h0080;
            4'd7:    v = 16'h0040;
            4'd8:    v = 16'h0020;
            4'd9:    v = 16'h0010;
            4'd10:   v = 16'h0008;
            4'd11:   v = 16'h0004;
            4'd12:   v = 16'h0002;
            4'd13:   v = 16'h0001;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/apb_cordic_slave_core.sv
// Iterative CORDIC engine: one micro-rotation per clock, ITER iterations per
// operation. Loads operands on start_i while idle, raises done_pulse_o on the
// edge that finishes the last iteration and latches saturated results.
// Handshake: start_i is sampled only in IDLE; busy_o is high for exactly ITER
// cycles after the start edge; done_pulse_o is high for the single cycle whose
// closing edge loads the results.
module apb_cordic_slave_core
    import apb_cordic_slave_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 14,
    parameter int GUARD = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [WIDTH-1:0] z_i,
    output logic             busy_o,
    output logic             done_pulse_o,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o,
    output logic [WIDTH-1:0] z_o,
    output logic             state_o
);

    localparam int XW = WIDTH + GUARD;
    localparam int CW = $clog2(ITER + 1);

    eng_state_e                 state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       mode_q, mode_d;
    logic signed [XW-1:0]       x_q, x_d, y_q, y_d;
    logic signed [WIDTH-1:0]    z_q, z_d;
    logic [WIDTH-1:0]           xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;

    logic signed [XW-1:0]       x_sh, y_sh, x_nx, y_nx;
    logic signed [WIDTH-1:0]    z_nx, atan_v;
    logic                       dir_pos;
    logic                       last_iter;

    // Clamp the guarded datapath value into the signed WIDTH output range
    function automatic logic [WIDTH-1:0] sat(input logic [XW-1:0] v);
        logic [GUARD:0] hi_bits;
        hi_bits = v[XW-1:WIDTH-1];
        if ((&hi_bits) || !(|hi_bits)) begin
            return v[WIDTH-1:0];
        end else if (v[XW-1]) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end
    endfunction

    assign x_sh      = x_q >>> cnt_q;
    assign y_sh      = y_q >>> cnt_q;
    assign atan_v    = WIDTH'(atan_rom(4'(cnt_q)));
    assign last_iter = (cnt_q == CW'(ITER - 1));

    // Rotation steers z toward 0; vectoring steers y toward 0
    assign dir_pos = mode_q ? y_q[XW-1] : ~z_q[WIDTH-1];

    // One micro-rotation of the current x/y/z state
    always_comb begin
        if (dir_pos) begin
            x_nx = x_q - y_sh;
            y_nx = y_q + x_sh;
            z_nx = z_q - atan_v;
        end else begin
            x_nx = x_q + y_sh;
            y_nx = y_q - x_sh;
            z_nx = z_q + atan_v;
        end
    end

    // Engine FSM next-state, datapath and result capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        x_d          = x_q;
        y_d          = y_q;
        z_d          = z_q;
        xo_d         = xo_q;
        yo_d         = yo_q;
        zo_d         = zo_q;
        done_pulse_o = 1'b0;
        case (state_q)
            ENG_IDLE: begin
                if (start_i) begin
                    state_d = ENG_RUN;
                    cnt_d   = '0;
                    mode_d  = mode_i;
                    x_d     = {{GUARD{x_i[WIDTH-1]}}, x_i};
                    y_d     = {{GUARD{y_i[WIDTH-1]}}, y_i};
                    z_d     = z_i;
                end
            end
            ENG_RUN: begin
                x_d   = x_nx;
                y_d   = y_nx;
                z_d   = z_nx;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d      = ENG_IDLE;
                    done_pulse_o = 1'b1;
                    xo_d         = sat(x_nx);
                    yo_d         = sat(y_nx);
                    zo_d         = z_nx;
                end
            end
            default: state_d = ENG_IDLE;
        endcase
    end

    // Engine state and datapath registers; reset aborts any running operation
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ENG_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            zo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            zo_q    <= zo_d;
        end
    end

    assign busy_o  = (state_q == ENG_RUN);
    assign state_o = state_q;
    assign x_o     = xo_q;
    assign y_o     = yo_q;
    assign z_o     = zo_q;

endmodule

// File: rtl/apb_cordic_slave.sv
// APB completer fronting the iterative CORDIC engine. Holds the operand,
// CTRL and STATUS registers, the register decode, wait-state generation,
// read-data mux and the interrupt output.
// APB handshake: a transfer is setup (PSEL=1, PENABLE=0) then access
// (PSEL=1, PENABLE=1); it completes on the rising edge where PREADY=1 during
// access. PREADY drops only for result reads and operand/CTRL writes while
// the engine is busy, so stalled writes land on the first edge after BUSY falls.
module apb_cordic_slave
    import apb_cordic_slave_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 14,
    parameter int GUARD = 2
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        irq
);

    logic [2:0]       addr;
    logic             access_ph;
    logic             stall_sel;
    logic             wr_commit;
    logic             start;

    logic             busy;
    logic             done_pulse;
    logic [WIDTH-1:0] x_out, y_out, z_out;
    logic             eng_state;

    logic             mode_q, mode_d;
    logic             ie_q, ie_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] x_in_q, x_in_d;
    logic [WIDTH-1:0] y_in_q, y_in_d;
    logic [WIDTH-1:0] z_in_q, z_in_d;

    // Address/data bits outside the decoded range, plus the engine state
    // that is only kept visible for checkers
    logic             unused_bits;
    assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:WIDTH], eng_state};

    function automatic logic [31:0] sext(input logic [WIDTH-1:0] v);
        return {{(32-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    assign addr      = PADDR[4:2];
    assign access_ph = PSEL && PENABLE;

    // Accesses that must wait for the engine to go idle
    always_comb begin
        stall_sel = 1'b0;
        if (PWRITE) begin
            case (addr)
                ADDR_CTRL, ADDR_X_IN, ADDR_Y_IN, ADDR_Z_IN: stall_sel = 1'b1;
                default: ;
            endcase
        end else begin
            case (addr)
                ADDR_X_OUT, ADDR_Y_OUT, ADDR_Z_OUT: stall_sel = 1'b1;
                default: ;
            endcase
        end
    end

    assign PREADY    = !(access_ph && busy && stall_sel);
    assign wr_commit = access_ph && PWRITE && PREADY;
    assign start     = wr_commit && (addr == ADDR_CTRL) && PWDATA[CTRL_START];

    // Register write decode and DONE tracking (completion beats W1C)
    always_comb begin
        mode_d = mode_q;
        ie_d   = ie_q;
        done_d = done_q;
        x_in_d = x_in_q;
        y_in_d = y_in_q;
        z_in_d = z_in_q;
        if (wr_commit) begin
            case (addr)
                ADDR_CTRL: begin
                    mode_d = PWDATA[CTRL_MODE];
                    ie_d   = PWDATA[CTRL_IE];
                end
                ADDR_STATUS: begin
                    if (PWDATA[STAT_DONE]) done_d = 1'b0;
                end
                ADDR_X_IN: x_in_d = PWDATA[WIDTH-1:0];
                ADDR_Y_IN: y_in_d = PWDATA[WIDTH-1:0];
                ADDR_Z_IN: z_in_d = PWDATA[WIDTH-1:0];
                default: ;
            endcase
        end
        if (start)      done_d = 1'b0;
        if (done_pulse) done_d = 1'b1;
    end

    // Software-visible register state
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mode_q <= 1'b0;
            ie_q   <= 1'b0;
            done_q <= 1'b0;
            x_in_q <= '0;
            y_in_q <= '0;
            z_in_q <= '0;
        end else begin
            mode_q <= mode_d;
            ie_q   <= ie_d;
            done_q <= done_d;
            x_in_q <= x_in_d;
            y_in_q <= y_in_d;
            z_in_q <= z_in_d;
        end
    end

    // Read mux: drives data only for a non-stalled read, zero otherwise
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE && PREADY) begin
            case (addr)
                ADDR_CTRL: begin
                    PRDATA[CTRL_MODE] = mode_q;
                    PRDATA[CTRL_IE]   = ie_q;
                end
                ADDR_STATUS: begin
                    PRDATA[STAT_BUSY] = busy;
                    PRDATA[STAT_DONE] = done_q;
                end
                ADDR_X_IN:  PRDATA = sext(x_in_q);
                ADDR_Y_IN:  PRDATA = sext(y_in_q);
                ADDR_Z_IN:  PRDATA = sext(z_in_q);
                ADDR_X_OUT: PRDATA = sext(x_out);
                ADDR_Y_OUT: PRDATA = sext(y_out);
                ADDR_Z_OUT: PRDATA = sext(z_out);
                default: ;
            endcase
        end
    end

    assign irq = done_q && ie_q;

    apb_cordic_slave_core #(
        .WIDTH (WIDTH),
        .ITER  (ITER),
        .GUARD (GUARD)
    ) u_core (
        .clk_i        (HCLK),
        .rst_ni       (HRESETn),
        .start_i      (start),
        .mode_i       (PWDATA[CTRL_MODE]),
        .x_i          (x_in_q),
        .y_i          (y_in_q),
        .z_i          (z_in_q),
        .busy_o       (busy),
        .done_pulse_o (done_pulse),
        .x_o          (x_out),
        .y_o          (y_out),
        .z_o          (z_out),
        .state_o      (eng_state)
    );

endmodule

// File: tb/tb_apb_cordic_slave.sv
// Bench for apb_cordic_slave: APB driver tasks, a read scoreboard fed with
// expected values before each read and drained by a monitor, and a
// high-level CORDIC reference computed with integer arithmetic.
module tb_apb_cordic_slave;

    localparam int ITER = 14;

    localparam logic [2:0] R_CTRL = 3'd0;
    localparam logic [2:0] R_STAT = 3'd1;
    localparam logic [2:0] R_XI   = 3'd2;
    localparam logic [2:0] R_YI   = 3'd3;
    localparam logic [2:0] R_ZI   = 3'd4;
    localparam logic [2:0] R_XO   = 3'd5;
    localparam logic [2:0] R_YO   = 3'd6;
    localparam logic [2:0] R_ZO   = 3'd7;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    int          tol_q[$];
    string       tag_q[$];

    int atan_tab[16];

    // ---------------- clock / reset ----------------
    always #5 HCLK = ~HCLK;

    apb_cordic_slave dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .irq     (irq)
    );

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp, input int tol);
        int diff;
        checks++;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d) tol %0d",
                     name, act, act, exp, exp, tol);
        end
    endtask

    // Monitor: every completed read is compared against the oldest expectation
    logic [31:0] mon_exp;
    int          mon_tol;
    string       mon_tag;
    always @(negedge HCLK) begin
        if (HRESETn && PSEL && PENABLE && !PWRITE && PREADY) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: PRDATA=0x%08h with no pending expectation", PRDATA);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_tol = tol_q.pop_front();
                mon_tag = tag_q.pop_front();
                check(mon_tag, int'(PRDATA), int'(mon_exp), mon_tol);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int wrap16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // CORDIC with arithmetic shifts; x/y saturate, z wraps at 16 bits
    function automatic void cordic_model(input int mode, input int xi, input int yi, input int zi,
                                         output int xo, output int yo, output int zo);
        int x, y, z, xn, d;
        x = xi;
        y = yi;
        z = zi;
        for (int i = 0; i < ITER; i++) begin
            if (mode == 0) d = (z >= 0) ? 1 : -1;
            else           d = (y < 0)  ? 1 : -1;
            xn = x - d * (y >>> i);
            y  = y + d * (x >>> i);
            x  = xn;
            z  = wrap16(z - d * atan_tab[i]);
        end
        xo = sat16(x);
        yo = sat16(y);
        zo = z;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apb_xfer(input logic wr, input logic [2:0] ra, input logic [31:0] wd, output int waits);
        logic [31:0] pa;
        pa = $urandom();
        pa[4:2] = ra;
        @(posedge HCLK); #1;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = pa;
        PWDATA  = wd;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        waits   = 0;
        @(negedge HCLK);
        while (!PREADY && waits < 200) begin
            waits++;
            @(negedge HCLK);
        end
        if (!PREADY) begin
            checks++;
            errors++;
            $display("FAIL apb_timeout: reg %0d still stalled after %0d cycles, required completion", ra, waits);
        end
        @(posedge HCLK); #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] ra, input logic [31:0] wd);
        int w;
        apb_xfer(1'b1, ra, wd, w);
    endtask

    task automatic wr_w(input logic [2:0] ra, input logic [31:0] wd, output int w);
        apb_xfer(1'b1, ra, wd, w);
    endtask

    task automatic rd(input logic [2:0] ra, input string tag, input int exp, input int tol);
        int w;
        exp_q.push_back(32'(exp));
        tol_q.push_back(tol);
        tag_q.push_back(tag);
        apb_xfer(1'b0, ra, 32'd0, w);
    endtask

    task automatic rd_w(input logic [2:0] ra, input string tag, input int exp, input int tol, output int w);
        exp_q.push_back(32'(exp));
        tol_q.push_back(tol);
        tag_q.push_back(tag);
        apb_xfer(1'b0, ra, 32'd0, w);
    endtask

    // One randomized operation checked bit-exactly against the model
    task automatic random_op();
        logic signed [15:0] xs, ys, zs;
        logic [31:0] junk, ctrl_w;
        int mode, ie, mx, my, mz, w;
        xs   = 16'($urandom_range(0, 65535));
        ys   = 16'($urandom_range(0, 65535));
        zs   = 16'($urandom_range(0, 65535));
        mode = $urandom_range(0, 1);
        ie   = $urandom_range(0, 1);
        cordic_model(mode, int'(xs), int'(ys), int'(zs), mx, my, mz);
        junk = $urandom();
        wr(R_XI, {junk[31:16], xs});
        junk = $urandom();
        wr(R_YI, {junk[31:16], ys});
        junk = $urandom();
        wr(R_ZI, {junk[31:16], zs});
        ctrl_w = ($urandom() & 32'hFFFF_FFF8) | {29'd0, ie[0], mode[0], 1'b1};
        wr(R_CTRL, ctrl_w);
        rd_w(R_XO, "rand_x_out", mx, 0, w);
        check("rand_x_out_wait", w, ITER - 2, 0);
        rd(R_YO, "rand_y_out", my, 0);
        rd(R_ZO, "rand_z_out", mz, 0);
        rd(R_STAT, "rand_status_done", 2, 0);
        rd(R_CTRL, "rand_ctrl_readback", (ie << 2) | (mode << 1), 0);
        @(negedge HCLK);
        check("rand_irq", int'(irq), ie, 0);
        wr(R_XO, $urandom());
        rd(R_XO, "rand_ro_write_ignored", mx, 0);
        wr(R_STAT, 32'h2);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w, mx, my, mz;
        for (int i = 0; i < 16; i++) begin
            atan_tab[i] = $rtoi($atan(1.0 / real'(1 << i)) * 8192.0 + 0.5);
        end

        HRESETn = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;

        // Reset state, probed with a result-register read in progress
        repeat (2) @(posedge HCLK);
        #1;
        PSEL = 1'b1; PENABLE = 1'b1; PADDR = 32'h14;
        @(negedge HCLK);
        check("rst_pready", int'(PREADY), 1, 0);
        check("rst_prdata", int'(PRDATA), 0, 0);
        check("rst_irq", int'(irq), 0, 0);
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        HRESETn = 1'b1;
        for (int r = 0; r < 8; r++) begin
            rd(3'(r), $sformatf("rst_reg%0d", r), 0, 0);
        end

        // Rotation by pi/4 of (1/K, 0); X_OUT read issued right after START
        wr(R_XI, 32'h136F);
        wr(R_YI, 32'h0);
        wr(R_ZI, 32'h1922);
        wr(R_CTRL, 32'h1);
        rd_w(R_XO, "rot_x_out", 32'h16A1, 4, w);
        check("rot_x_out_wait", w, ITER - 2, 0);
        rd(R_YO, "rot_y_out", 32'h16A1, 4);
        rd(R_ZO, "rot_z_out", 0, 2);
        rd(R_STAT, "rot_status", 2, 0);
        cordic_model(0, 32'h136F, 0, 32'h1922, mx, my, mz);
        rd(R_XO, "rot_x_model", mx, 0);

        // Operand write during a run waits and leaves the run untouched
        wr(R_CTRL, 32'h1);
        wr_w(R_XI, 32'h7FFF, w);
        check("midrun_write_wait", w, ITER - 2, 0);
        rd(R_XO, "midrun_x_out", mx, 0);
        rd(R_YO, "midrun_y_out", my, 0);
        rd(R_XI, "midrun_x_in", 32'h7FFF, 0);

        // Vectoring of (1, 1); STATUS mid-run shows BUSY only, no stall
        wr(R_XI, 32'h2000);
        wr(R_YI, 32'h2000);
        wr(R_ZI, 32'h0);
        wr(R_CTRL, 32'h3);
        rd_w(R_STAT, "vec_status_midrun", 1, 0, w);
        check("vec_status_wait", w, 0, 0);
        rd(R_ZO, "vec_z_out", 32'h1922, 2);
        rd(R_XO, "vec_x_out", 32'h4A87, 6);
        rd(R_YO, "vec_y_out", 0, 2);

        // Back-to-back START: second one waits, then runs with its own MODE
        wr(R_CTRL, 32'h1);
        wr_w(R_CTRL, 32'h3, w);
        check("b2b_start_wait", w, ITER - 2, 0);
        cordic_model(1, 32'h2000, 32'h2000, 0, mx, my, mz);
        rd(R_XO, "b2b_x_out", mx, 0);
        rd(R_ZO, "b2b_z_out", mz, 0);

        // DONE W1C landing on the completion edge: completion wins
        wr(R_CTRL, 32'h1);
        repeat (ITER - 3) @(posedge HCLK);
        wr(R_STAT, 32'h2);
        rd(R_STAT, "w1c_vs_done", 2, 0);
        wr(R_STAT, 32'h2);
        rd(R_STAT, "w1c_clear", 0, 0);

        // Interrupt timing and clear
        wr(R_CTRL, 32'h5);
        repeat (ITER) @(negedge HCLK);
        check("irq_before_done", int'(irq), 0, 0);
        @(negedge HCLK);
        check("irq_at_done", int'(irq), 1, 0);
        wr(R_STAT, 32'h2);
        @(negedge HCLK);
        check("irq_cleared", int'(irq), 0, 0);

        // Reset in the middle of a run aborts it
        wr(R_CTRL, 32'h5);
        repeat (5) @(posedge HCLK);
        #2;
        HRESETn = 1'b0;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h14;
        #1;
        check("abort_pready", int'(PREADY), 1, 0);
        check("abort_prdata", int'(PRDATA), 0, 0);
        check("abort_irq", int'(irq), 0, 0);
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        HRESETn = 1'b1;
        rd(R_STAT, "abort_status", 0, 0);
        rd(R_XO, "abort_x_out", 0, 0);
        rd(R_YO, "abort_y_out", 0, 0);
        rd(R_ZO, "abort_z_out", 0, 0);
        rd(R_CTRL, "abort_ctrl", 0, 0);
        repeat (ITER + 4) @(negedge HCLK);
        check("abort_no_irq", int'(irq), 0, 0);
        rd(R_STAT, "abort_no_done", 0, 0);

        // Randomized operations
        for (int n = 0; n < 24; n++) begin
            random_op();
        end

        // PSEL dropped during a stalled write: no update, run unaffected
        wr(R_XI, 32'h0ABC);
        wr(R_YI, 32'h0123);
        wr(R_ZI, 32'h0800);
        wr(R_CTRL, 32'h1);
        @(posedge HCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'h1234;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        @(negedge HCLK);
        check("drop_stalled", int'(PREADY), 0, 0);
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        cordic_model(0, 32'h0ABC, 32'h0123, 32'h0800, mx, my, mz);
        rd(R_XO, "drop_x_out", mx, 0);
        rd(R_YO, "drop_y_out", my, 0);
        rd(R_XI, "drop_x_in", 32'h0ABC, 0);

        // Drain the scoreboard
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge HCLK);
        while (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_read: %s never observed, expected 0x%08h", tag_q[0], exp_q[0]);
            void'(exp_q.pop_front());
            void'(tol_q.pop_front());
            void'(tag_q.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
